// File: rtl/config_loader.sv
// Write-side sequencer for the configuration latch array: takes a valid/ready word stream and
// replays it bank by bank as setup / enable pulse / hold triplets on a shared data bus.
module config_loader #(
    parameter int unsigned DATA_W       = 32,
    parameter int unsigned NUM_WORDS    = 28,
    parameter int unsigned PULSE_CYCLES = 1,
    parameter int unsigned IDX_W        = 5
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 io_start,
    input  logic                 io_in_valid,
    output logic                 io_in_ready,
    input  logic [DATA_W-1:0]    io_in_bits,
    output logic [DATA_W-1:0]    io_d_out,
    output logic [NUM_WORDS-1:0] io_configs_en,
    output logic [IDX_W-1:0]     io_word_idx,
    output logic                 io_busy,
    output logic                 io_done
);

    typedef enum logic [2:0] {
        StIdle,
        StWaitWord,
        StSetup,
        StPulse,
        StHold,
        StDone
    } state_e;

    localparam logic [IDX_W-1:0]     IdxLast   = IDX_W'(NUM_WORDS - 1);
    localparam logic [3:0]           PulseLast = 4'(PULSE_CYCLES - 1);
    localparam logic [NUM_WORDS-1:0] EnOne     = NUM_WORDS'(1);

    state_e                 state_q;
    logic [IDX_W-1:0]       idx_q;
    logic [3:0]             cnt_q;
    logic                   ready_q;
    logic                   busy_q;
    logic                   done_q;
    logic [DATA_W-1:0]      d_out_q;
    logic [NUM_WORDS-1:0]   en_q;

    // Every output is a flop, so the latch enables can never glitch.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            idx_q   <= '0;
            cnt_q   <= '0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            d_out_q <= '0;
            en_q    <= '0;
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (io_start) begin
                        state_q <= StWaitWord;
                        idx_q   <= '0;
                        done_q  <= 1'b0;
                        busy_q  <= 1'b1;
                        ready_q <= 1'b1;
                    end
                end
                StWaitWord: begin
                    if (io_in_valid && ready_q) begin
                        d_out_q <= io_in_bits;
                        ready_q <= 1'b0;
                        state_q <= StSetup;
                    end
                end
                StSetup: begin
                    en_q    <= EnOne << idx_q;
                    cnt_q   <= '0;
                    state_q <= StPulse;
                end
                StPulse: begin
                    if (cnt_q == PulseLast) begin
                        en_q    <= '0;
                        state_q <= StHold;
                    end else begin
                        cnt_q <= cnt_q + 4'd1;
                    end
                end
                StHold: begin
                    if (idx_q == IdxLast) begin
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
                        state_q <= StDone;
                    end else begin
                        idx_q   <= idx_q + IDX_W'(1);
                        ready_q <= 1'b1;
                        state_q <= StWaitWord;
                    end
                end
                default: begin
                    state_q <= StIdle;
                    en_q    <= '0;
                    ready_q <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign io_in_ready   = ready_q;
    assign io_d_out      = d_out_q;
    assign io_configs_en = en_q;
    assign io_word_idx   = idx_q;
    assign io_busy       = busy_q;
    assign io_done       = done_q;

endmodule

// File: tb/tb_config_loader.sv
// Bench for config_loader: two instances (1- and 3-cycle pulses) driven in lockstep and compared
// every cycle against a handshake-timeline model, plus a fixed table of expected waveform points.
module tb_config_loader;

    localparam int DW = 32;
    localparam int NW = 28;
    localparam int IW = 5;

    logic clk = 1'b0;
    logic reset;
    logic start;
    logic          valid [2];
    logic [DW-1:0] bits  [2];
    logic          rdy   [2];
    logic          busy  [2];
    logic          done  [2];
    logic [DW-1:0] dout  [2];
    logic [NW-1:0] en    [2];
    logic [IW-1:0] widx  [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        config_loader #(
            .DATA_W      (DW),
            .NUM_WORDS   (NW),
            .PULSE_CYCLES((g == 0) ? 1 : 3),
            .IDX_W       (IW)
        ) u_dut (
            .clk          (clk),
            .reset        (reset),
            .io_start     (start),
            .io_in_valid  (valid[g]),
            .io_in_ready  (rdy[g]),
            .io_in_bits   (bits[g]),
            .io_d_out     (dout[g]),
            .io_configs_en(en[g]),
            .io_word_idx  (widx[g]),
            .io_busy      (busy[g]),
            .io_done      (done[g])
        );
    end

    int n_checks = 0;
    int n_pass   = 0;

    // Model: a word's life is measured in cycles since its handshake (m_t). The enable is high
    // for t in 1..PC, and the next word becomes acceptable once t reaches PC+2.
    bit            m_busy [2];
    bit            m_wait [2];
    bit            m_done [2];
    int            m_t    [2];
    int            m_idx  [2];
    logic [DW-1:0] m_dout [2];
    int            pcount [2][NW];

    typedef struct {
        int            cyc;
        logic          rdy;
        logic          busy;
        logic          done;
        int            idx;
        logic [NW-1:0] en;
        logic [DW-1:0] dout;
    } vec_t;

    vec_t tbl [9];

    function automatic int pc_of(input int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic logic [NW-1:0] exp_en(input int k);
        logic [NW-1:0] one = NW'(1);
        if (m_busy[k] && !m_wait[k] && m_t[k] >= 1 && m_t[k] <= pc_of(k)) return one << m_idx[k];
        return '0;
    endfunction

    task automatic check(input bit ok, input string msg);
        n_checks++;
        if (ok) n_pass++;
        else $display("FAIL %s", msg);
    endtask

    task automatic model_reset(input int k);
        m_busy[k] = 0; m_wait[k] = 0; m_done[k] = 0; m_t[k] = 0; m_idx[k] = 0; m_dout[k] = '0;
        for (int b = 0; b < NW; b++) pcount[k][b] = 0;
    endtask

    task automatic model_edge(input int k, input bit r, input bit s, input bit v,
                              input logic [DW-1:0] b, output bit hs, output bit fresh);
        hs = 0;
        fresh = 0;
        if (r) begin
            model_reset(k);
            fresh = 1;
        end else if (!m_busy[k]) begin
            if (s) begin
                m_busy[k] = 1; m_wait[k] = 1; m_done[k] = 0; m_idx[k] = 0; m_t[k] = 0;
                for (int i = 0; i < NW; i++) pcount[k][i] = 0;
                fresh = 1;
            end
        end else if (m_wait[k]) begin
            if (v) begin
                m_dout[k] = b; m_wait[k] = 0; m_t[k] = 0; hs = 1;
            end
        end else begin
            m_t[k]++;
            if (m_t[k] == pc_of(k) + 2) begin
                if (m_idx[k] == NW - 1) begin
                    m_busy[k] = 0; m_done[k] = 1;
                end else begin
                    m_idx[k]++; m_wait[k] = 1;
                end
            end
        end
    endtask

    task automatic cmp(input int k, input int cyc);
        logic          e_rdy  = m_busy[k] && m_wait[k];
        logic [NW-1:0] e_en   = exp_en(k);
        bit ok = (rdy[k] === e_rdy) && (busy[k] === m_busy[k]) && (done[k] === m_done[k]) &&
                 (widx[k] === IW'(m_idx[k])) && (en[k] === e_en) && (dout[k] === m_dout[k]);
        check(ok, $sformatf("cyc%0d dut%0d got rdy=%b busy=%b done=%b idx=%0d en=%h dout=%h, need rdy=%b busy=%b done=%b idx=%0d en=%h dout=%h",
              cyc, k, rdy[k], busy[k], done[k], widx[k], en[k], dout[k],
              e_rdy, m_busy[k], m_done[k], m_idx[k], e_en, m_dout[k]));
        for (int b = 0; b < NW; b++) if (en[k][b] === 1'b1) pcount[k][b]++;
    endtask

    task automatic tbl_check(input int cyc);
        for (int i = 0; i < 9; i++) begin
            if (tbl[i].cyc == cyc) begin
                check(rdy[0] === tbl[i].rdy && busy[0] === tbl[i].busy && done[0] === tbl[i].done &&
                      widx[0] === IW'(tbl[i].idx) && en[0] === tbl[i].en && dout[0] === tbl[i].dout,
                      $sformatf("table cyc%0d got rdy=%b busy=%b done=%b idx=%0d en=%h dout=%h, need rdy=%b busy=%b done=%b idx=%0d en=%h dout=%h",
                      cyc, rdy[0], busy[0], done[0], widx[0], en[0], dout[0], tbl[i].rdy,
                      tbl[i].busy, tbl[i].done, tbl[i].idx, tbl[i].en, tbl[i].dout));
            end
        end
    endtask

    // mode: 0 plain, 1 backpressure before word 7, 2 start while busy, 3 reset mid-pulse, 4 random
    task automatic run_seq(input int mode, input logic [DW-1:0] base, input bit use_tbl);
        int acc [2];
        int gap [2];
        int hs  [2];
        int cyc = 0;
        bit busy_spent = 0, rst_spent = 0, restarted = 0;
        bit hs_m, fresh;
        for (int k = 0; k < 2; k++) begin
            acc[k] = 0; gap[k] = 0; hs[k] = 0;
        end
        while (cyc < 3000) begin
            if (cyc > 0 && m_done[0] && m_done[1]) break;
            reset = (mode == 3 && !rst_spent && m_idx[0] == 5 && exp_en(0) != '0);
            start = (cyc == 0);
            if (mode == 2 && !busy_spent && m_busy[0] && m_idx[0] == 12) begin
                start = 1; busy_spent = 1;
            end
            if (mode == 3 && rst_spent && !restarted) begin
                start = 1; restarted = 1;
            end
            if (mode == 4 && m_busy[0] && m_busy[1] && $urandom_range(0, 19) == 0) start = 1;
            if (reset) rst_spent = 1;
            for (int k = 0; k < 2; k++) begin
                if (mode == 1) begin
                    valid[k] = !(acc[k] == 7 && gap[k] < 10);
                    if (acc[k] == 7 && m_wait[k] && gap[k] < 10) gap[k]++;
                end else if (mode == 4) begin
                    valid[k] = ($urandom_range(0, 3) != 0);
                end else begin
                    valid[k] = 1'b1;
                end
                bits[k] = (mode == 4) ? DW'($urandom) : base + DW'(acc[k]);
                if (valid[k] && rdy[k] === 1'b1) hs[k]++;
            end
            @(posedge clk);
            for (int k = 0; k < 2; k++) begin
                model_edge(k, reset, start, valid[k], bits[k], hs_m, fresh);
                if (hs_m) acc[k]++;
                if (fresh) begin
                    acc[k] = 0; hs[k] = 0;
                end
            end
            #1;
            for (int k = 0; k < 2; k++) cmp(k, cyc + 1);
            if (use_tbl) tbl_check(cyc + 1);
            cyc++;
        end
        check(m_done[0] && m_done[1], $sformatf("timeout mode%0d got done=%b%b, need 11",
              mode, done[0], done[1]));
        if (mode != 4) begin
            for (int k = 0; k < 2; k++) begin
                check(hs[k] == NW, $sformatf("handshakes mode%0d dut%0d got %0d, need %0d",
                      mode, k, hs[k], NW));
                for (int b = 0; b < NW; b++)
                    check(pcount[k][b] == pc_of(k), $sformatf("pulse mode%0d dut%0d bit%0d got %0d cycles, need %0d",
                          mode, k, b, pcount[k][b], pc_of(k)));
            end
        end
        reset = 0;
        start = 0;
        for (int k = 0; k < 2; k++) valid[k] = 0;
        repeat (2) begin
            @(posedge clk);
            #1;
            for (int k = 0; k < 2; k++) cmp(k, -1);
        end
    endtask

    initial begin
        bit hs_m, fresh;
        tbl[0] = '{1,   1'b1, 1'b1, 1'b0, 0,  28'h0,       32'h0};
        tbl[1] = '{2,   1'b0, 1'b1, 1'b0, 0,  28'h0,       32'hA500_0000};
        tbl[2] = '{3,   1'b0, 1'b1, 1'b0, 0,  28'h1,       32'hA500_0000};
        tbl[3] = '{4,   1'b0, 1'b1, 1'b0, 0,  28'h0,       32'hA500_0000};
        tbl[4] = '{5,   1'b1, 1'b1, 1'b0, 1,  28'h0,       32'hA500_0000};
        tbl[5] = '{7,   1'b0, 1'b1, 1'b0, 1,  28'h2,       32'hA500_0001};
        tbl[6] = '{111, 1'b0, 1'b1, 1'b0, 27, 28'h800_0000, 32'hA500_001B};
        tbl[7] = '{112, 1'b0, 1'b1, 1'b0, 27, 28'h0,       32'hA500_001B};
        tbl[8] = '{113, 1'b0, 1'b0, 1'b1, 27, 28'h0,       32'hA500_001B};

        reset = 1'b1;
        start = 1'b1;
        for (int k = 0; k < 2; k++) begin
            valid[k] = 1'b0;
            bits[k]  = '0;
            model_reset(k);
        end
        repeat (2) begin
            @(posedge clk);
            for (int k = 0; k < 2; k++) model_edge(k, 1'b1, 1'b1, 1'b0, '0, hs_m, fresh);
            #1;
            for (int k = 0; k < 2; k++) cmp(k, 0);
        end
        reset = 1'b0;
        start = 1'b0;
        @(posedge clk);
        #1;
        for (int k = 0; k < 2; k++) cmp(k, 0);

        run_seq(0, 32'hA500_0000, 1'b1);
        run_seq(1, 32'hA500_0000, 1'b0);
        run_seq(2, 32'hB600_0000, 1'b0);
        run_seq(0, 32'h0000_0001, 1'b0);
        run_seq(3, 32'hC700_0000, 1'b0);
        run_seq(4, 32'h0,         1'b0);
        run_seq(4, 32'h0,         1'b0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
